// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture block.
package camera_pkg;
    localparam int CAM_BYTES_PER_WORD = 4;
    localparam int CAM_RAM_DEPTH_MAX  = 8192;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    typedef struct packed {
        logic       pclk;
        logic       vsync;
        logic       href;
        logic [7:0] data;
    } cam_bus_t;
endpackage

// File: rtl/capture_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, same clock.
// A read of the word being written in the same cycle returns the old contents.
module capture_frame_ram #(
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem[raddr_i];
        end
    end
endmodule

// File: rtl/camera_capture.sv
// Captures one camera frame per request into a word-packed frame RAM and serves word reads.
// Define CAMERA_CAPTURE_SYNC_EN to put a two-flop synchronizer on the CAM_* inputs.
module camera_capture
    import camera_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    input  logic [12:0] ADDR,
    output logic [31:0] RDATA,
    input  logic        CAM_PCLK,
    input  logic        CAM_VSYNC,
    input  logic        CAM_HREF,
    input  logic [7:0]  CAM_DATA,
    output logic [13:0] FRAME_WORDS,
    output logic        OVERFLOW
);
    localparam logic [AW:0] FULL_ADDR = (AW+1)'(DEPTH);

    cam_bus_t    cam_pins;
    cam_bus_t    cam_q;
    logic        pclk_qq, vsync_qq;
    cap_state_t  state_q;
    logic        dv_q, ready_q, overflow_q;
    logic [AW:0] waddr_q;
    logic [13:0] frame_words_q;
    logic [31:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        pclk_rise, vs_rise, vs_fall, take, emit;

    assign cam_pins = {CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA};

`ifdef CAMERA_CAPTURE_SYNC_EN
    cam_bus_t cam_meta_q;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cam_meta_q <= '0;
            cam_q      <= '0;
        end else begin
            cam_meta_q <= cam_pins;
            cam_q      <= cam_meta_q;
        end
    end
`else
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cam_q <= '0;
        end else begin
            cam_q <= cam_pins;
        end
    end
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pclk_qq  <= 1'b0;
            vsync_qq <= 1'b0;
        end else begin
            pclk_qq  <= cam_q.pclk;
            vsync_qq <= cam_q.vsync;
        end
    end

    // Data travels through the same stages as PCLK, so it is aligned with the detected edge.
    assign pclk_rise = cam_q.pclk & ~pclk_qq;
    assign vs_rise   = cam_q.vsync & ~vsync_qq;
    assign vs_fall   = ~cam_q.vsync & vsync_qq;
    assign take      = (state_q == ST_CAPTURE) && pclk_rise && cam_q.href;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (take) begin
            word_d[8*cnt_q[1:0] +: 8] = cam_q.data;
            cnt_d = cnt_q + 3'd1;
        end
        // A byte coinciding with VSYNC rise is packed before the partial word is flushed.
        emit = (cnt_d == 3'(CAM_BYTES_PER_WORD)) || (vs_rise && (cnt_d != 3'd0));
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q       <= ST_IDLE;
            dv_q          <= 1'b0;
            ready_q       <= 1'b0;
            overflow_q    <= 1'b0;
            waddr_q       <= '0;
            frame_words_q <= '0;
            word_q        <= '0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            dv_q    <= DATA_VALID;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (DATA_VALID && !dv_q) begin
                        state_q       <= ST_WAIT_VS;
                        waddr_q       <= '0;
                        frame_words_q <= '0;
                        overflow_q    <= 1'b0;
                        word_q        <= '0;
                        cnt_q         <= '0;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (emit) begin
                        word_q <= '0;
                        cnt_q  <= '0;
                        // Once full the address parks at DEPTH; later words are dropped.
                        if (waddr_q == FULL_ADDR) begin
                            overflow_q <= 1'b1;
                        end else begin
                            wr_en_q       <= 1'b1;
                            wr_addr_q     <= waddr_q[AW-1:0];
                            wr_data_q     <= word_d;
                            waddr_q       <= waddr_q + 1'b1;
                            frame_words_q <= frame_words_q + 14'd1;
                        end
                    end else begin
                        word_q <= word_d;
                        cnt_q  <= cnt_d;
                    end
                    if (vs_rise) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    capture_frame_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .we_i    (wr_en_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .raddr_i (ADDR[AW-1:0]),
        .rdata_o (RDATA)
    );

    assign DATA_READY  = ready_q;
    assign FRAME_WORDS = frame_words_q;
    assign OVERFLOW    = overflow_q;
endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture with a small frame RAM so the full boundary is reachable.
module tb_camera_capture;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        HCLK = 1'b0;
    logic        HRESET, DATA_VALID, DATA_READY;
    logic [12:0] ADDR;
    logic [31:0] RDATA;
    logic        CAM_PCLK, CAM_VSYNC, CAM_HREF;
    logic [7:0]  CAM_DATA;
    logic [13:0] FRAME_WORDS;
    logic        OVERFLOW;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_cnt  = 0;
    int rdy_base = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] rd [64];
    logic [31:0] exp_mem [DEPTH];

    always #5 HCLK = ~HCLK;

    camera_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
        .ADDR(ADDR), .RDATA(RDATA), .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC),
        .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA), .FRAME_WORDS(FRAME_WORDS), .OVERFLOW(OVERFLOW)
    );

    always @(negedge HCLK) if (DATA_READY === 1'b1) rdy_cnt++;

    // Reference model: the frame is just the byte list; words are 4 bytes LSB-first, capped at DEPTH.
    function automatic int exp_total();
        return (tx_q.size() + 3) / 4;
    endfunction
    function automatic int exp_fw();
        return (exp_total() > DEPTH) ? DEPTH : exp_total();
    endfunction
    function automatic logic exp_ov();
        return exp_total() > DEPTH;
    endfunction
    function automatic logic [31:0] exp_word(input int i);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            if (4*i + k < tx_q.size()) w = w | (32'(tx_q[4*i+k]) << (8*k));
        return w;
    endfunction
    task automatic update_mem();
        for (int i = 0; i < exp_fw(); i++) exp_mem[i] = exp_word(i);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge HCLK);
    endtask
    task automatic tick(input logic [7:0] d, input logic href);
        CAM_PCLK = 1'b0; CAM_DATA = d; CAM_HREF = href; cyc(2);
        CAM_PCLK = 1'b1; cyc(2);
    endtask
    task automatic blank(input int n);
        repeat (n) tick(8'h00, 1'b0);
    endtask
    task automatic fill_random(input int n);
        tx_q.delete();
        repeat (n) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask
    task automatic send_frame(input int bpl);
        CAM_VSYNC = 1'b1; blank(3);
        CAM_VSYNC = 1'b0; blank(2);
        for (int i = 0; i < tx_q.size(); i++) begin
            tick(tx_q[i], 1'b1);
            if ((i + 1) % bpl == 0) blank(2);
        end
        blank(1);
        CAM_VSYNC = 1'b1; blank(3);
    endtask
    task automatic request();
        rdy_base = rdy_cnt;
        DATA_VALID = 1'b1;
        cyc(2);
    endtask
    task automatic wait_ready(input int budget, input bit drop);
        int t;
        t = 0;
        while (rdy_cnt == rdy_base && t < budget) begin
            @(negedge HCLK); #1; t++;
        end
        n_checks++;
        if (rdy_cnt == rdy_base) begin
            n_fail++;
            $display("FAIL ready_timeout: no DATA_READY within %0d cycles, required a pulse", budget);
        end
        if (drop) DATA_VALID = 1'b0;
        cyc(4);
    endtask
    task automatic read_words(input int n);
        ADDR = 13'd0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            rd[i] = RDATA;
            ADDR = 13'(i + 1);
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1; DATA_VALID = 1'b0; ADDR = '0;
        CAM_PCLK = 1'b0; CAM_VSYNC = 1'b1; CAM_HREF = 1'b0; CAM_DATA = '0;
        cyc(3);
        n_checks += 4;
        if (DATA_READY !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", DATA_READY); end
        if (RDATA !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
        if (FRAME_WORDS !== 14'd0) begin n_fail++; $display("FAIL rst_fw: got %0d want 0", FRAME_WORDS); end
        if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", OVERFLOW); end
        HRESET = 1'b0;
        blank(2);
    endtask

    task automatic test_skip_frame();
        CAM_VSYNC = 1'b0; blank(1);
        repeat (6) tick(8'($urandom_range(0, 255)), 1'b1);
        request();
        repeat (6) tick(8'($urandom_range(0, 255)), 1'b1);
        blank(1);
        fill_random(16);
        send_frame(8);
        wait_ready(200, 1'b1);
        update_mem();
        n_checks += 3;
        if (FRAME_WORDS !== 14'd4) begin n_fail++; $display("FAIL skip_fw: got %0d want 4", FRAME_WORDS); end
        if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL skip_ovf: got %b want 0", OVERFLOW); end
        if (rdy_cnt - rdy_base != 1) begin n_fail++; $display("FAIL skip_pulses: got %0d want 1", rdy_cnt - rdy_base); end
        read_words(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd[i] !== exp_word(i)) begin n_fail++; $display("FAIL skip_word%0d: got %h want %h", i, rd[i], exp_word(i)); end
        end
    endtask

    task automatic test_partial();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        request();
        CAM_VSYNC = 1'b1; blank(2);
        CAM_VSYNC = 1'b0; blank(2);
        for (int i = 0; i < 4; i++) tick(tx_q[i], 1'b1);
        CAM_PCLK = 1'b0; CAM_DATA = 8'h55; CAM_HREF = 1'b1; cyc(2);
        CAM_PCLK = 1'b1; CAM_VSYNC = 1'b1; cyc(2);
        blank(3);
        wait_ready(200, 1'b1);
        update_mem();
        read_words(2);
        n_checks += 4;
        if (FRAME_WORDS !== 14'd2) begin n_fail++; $display("FAIL part_fw: got %0d want 2", FRAME_WORDS); end
        if (rd[0] !== 32'h44332211) begin n_fail++; $display("FAIL part_w0: got %h want 44332211", rd[0]); end
        if (rd[1] !== 32'h00000055) begin n_fail++; $display("FAIL part_w1: got %h want 00000055", rd[1]); end
        if (rdy_cnt - rdy_base != 1) begin n_fail++; $display("FAIL part_pulses: got %0d want 1", rdy_cnt - rdy_base); end
    endtask

    task automatic test_read_old();
        logic [31:0] old_w;
        old_w = exp_mem[0];
        fill_random(8);
        if (exp_word(0) == old_w) tx_q[0] = tx_q[0] ^ 8'h01;
        ADDR = 13'd0;
        request();
        fork
            send_frame(8);
            begin : watch
                int t;
                t = 0;
                while (FRAME_WORDS !== 14'd1 && t < 500) begin @(negedge HCLK); t++; end
                n_checks++;
                if (t >= 500 || RDATA !== old_w) begin
                    n_fail++; $display("FAIL rdw_old: got %h want %h", RDATA, old_w);
                end
            end
        join
        wait_ready(200, 1'b1);
        update_mem();
        n_checks++;
        if (RDATA !== exp_word(0)) begin n_fail++; $display("FAIL rdw_new: got %h want %h", RDATA, exp_word(0)); end
    endtask

    task automatic test_held_valid();
        int e_fw;
        logic [31:0] e0;
        fill_random(8);
        request();
        send_frame(8);
        wait_ready(200, 1'b0);
        update_mem();
        e_fw = exp_fw();
        e0 = exp_word(0);
        fill_random(20);
        send_frame(10);
        cyc(10);
        DATA_VALID = 1'b0;
        read_words(1);
        n_checks += 3;
        if (rdy_cnt - rdy_base != 1) begin n_fail++; $display("FAIL held_pulses: got %0d want 1", rdy_cnt - rdy_base); end
        if (FRAME_WORDS !== 14'(e_fw)) begin n_fail++; $display("FAIL held_fw: got %0d want %0d", FRAME_WORDS, e_fw); end
        if (rd[0] !== e0) begin n_fail++; $display("FAIL held_w0: got %h want %h", rd[0], e0); end
    endtask

    task automatic test_overflow();
        fill_random(80);
        request();
        send_frame(40);
        wait_ready(200, 1'b1);
        update_mem();
        n_checks += 3;
        if (FRAME_WORDS !== 14'd16) begin n_fail++; $display("FAIL ovf_fw: got %0d want 16", FRAME_WORDS); end
        if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", OVERFLOW); end
        if (rdy_cnt - rdy_base != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", rdy_cnt - rdy_base); end
        read_words(16);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rd[i] !== exp_word(i)) begin n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, rd[i], exp_word(i)); end
        end
    endtask

    task automatic test_reset_mid();
        fill_random(40);
        request();
        CAM_VSYNC = 1'b1; blank(2);
        CAM_VSYNC = 1'b0; blank(1);
        for (int i = 0; i < 40; i++) tick(tx_q[i], 1'b1);
        blank(2);
        n_checks++;
        if (FRAME_WORDS !== 14'd10) begin n_fail++; $display("FAIL mid_fw_pre: got %0d want 10", FRAME_WORDS); end
        HRESET = 1'b1; DATA_VALID = 1'b0;
        cyc(2);
        n_checks += 4;
        if (FRAME_WORDS !== 14'd0) begin n_fail++; $display("FAIL mid_fw: got %0d want 0", FRAME_WORDS); end
        if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b want 0", OVERFLOW); end
        if (DATA_READY !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", DATA_READY); end
        if (RDATA !== 32'h0) begin n_fail++; $display("FAIL mid_rdata: got %h want 0", RDATA); end
        CAM_VSYNC = 1'b1;
        cyc(2);
        HRESET = 1'b0;
        blank(2);
        n_checks++;
        if (rdy_cnt != rdy_base) begin n_fail++; $display("FAIL mid_pulses: got %0d want 0", rdy_cnt - rdy_base); end
        fill_random(12);
        request();
        send_frame(6);
        wait_ready(200, 1'b1);
        update_mem();
        read_words(3);
        n_checks++;
        if (FRAME_WORDS !== 14'd3) begin n_fail++; $display("FAIL mid_next_fw: got %0d want 3", FRAME_WORDS); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd[i] !== exp_word(i)) begin n_fail++; $display("FAIL mid_word%0d: got %h want %h", i, rd[i], exp_word(i)); end
        end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 4; it++) begin
            int lines, bpl;
            lines = $urandom_range(1, 3);
            bpl   = $urandom_range(1, 30);
            fill_random(lines * bpl);
            request();
            send_frame(bpl);
            wait_ready(200, 1'b1);
            update_mem();
            n_checks += 3;
            if (FRAME_WORDS !== 14'(exp_fw())) begin n_fail++; $display("FAIL rnd%0d_fw: got %0d want %0d", it, FRAME_WORDS, exp_fw()); end
            if (OVERFLOW !== exp_ov()) begin n_fail++; $display("FAIL rnd%0d_ovf: got %b want %b", it, OVERFLOW, exp_ov()); end
            if (rdy_cnt - rdy_base != 1) begin n_fail++; $display("FAIL rnd%0d_pulses: got %0d want 1", it, rdy_cnt - rdy_base); end
            read_words(exp_fw());
            for (int i = 0; i < exp_fw(); i++) begin
                n_checks++;
                if (rd[i] !== exp_word(i)) begin n_fail++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, rd[i], exp_word(i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_skip_frame();
        test_partial();
        test_read_old();
        test_held_valid();
        test_overflow();
        test_reset_mid();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end
endmodule
